// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the ram arbiter.
// Width helpers and request/response bundles.
package ram_arb_pkg;

  localparam int NUM_REQ_DEF = 2;
  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int IDX_W       = $clog2(NUM_REQ_DEF);

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } ram_req_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] rdata;
    logic                  err;
  } ram_rsp_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a pointer that moves only on a handshake.
// Grant is combinational from the request bits and the pointer.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IW = idx_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               hs,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx
);

  logic [IW-1:0] last_grant;
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = last_grant;
    cand  = '0;
    found = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IW'((int'(last_grant) + off) % NUM_REQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

  // Reset points at the last requester so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= IW'(NUM_REQ - 1);
    end else if (hs) begin
      last_grant <= idx;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port ram between NUM_REQ requesters.
// One access per cycle, response tagged one cycle later.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int RAM_SIZE = 1024,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_W-1:0]              rsp_rdata,
  output logic                           rsp_err,
  output logic [ADDR_W-1:0]              ram_address,
  output logic [DATA_W-1:0]              ram_wr_data,
  output logic                           ram_we,
  input  logic [DATA_W-1:0]              ram_rd_data
);

  localparam int IW = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gidx;
  logic               hs;
  logic               oor;
  logic [ADDR_W-1:0]  g_addr;
  logic [DATA_W-1:0]  g_wdata;
  logic               g_we;
  logic [ADDR_W-1:0]  last_addr;
  logic               rsp_pend;
  logic [IW-1:0]      rsp_idx;
  logic               rsp_oor;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req_valid),
    .hs   (hs),
    .gnt  (gnt),
    .idx  (gidx)
  );

  assign req_ready = rst_n ? gnt : '0;
  assign hs        = |req_ready;

  assign g_addr  = req_addr[gidx];
  assign g_wdata = req_wdata[gidx];
  assign g_we    = req_we[gidx];
  assign oor     = {1'b0, g_addr} >= (ADDR_W+1)'(RAM_SIZE);

  // Out-of-range accesses are accepted but never write the array.
  assign ram_we      = hs & g_we & ~oor;
  assign ram_wr_data = hs ? g_wdata : '0;
  assign ram_address = !rst_n ? '0 : (hs ? g_addr : last_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_addr <= '0;
      rsp_pend  <= 1'b0;
      rsp_idx   <= '0;
      rsp_oor   <= 1'b0;
    end else begin
      rsp_pend <= hs;
      if (hs) begin
        last_addr <= g_addr;
        rsp_idx   <= gidx;
        rsp_oor   <= oor;
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (rsp_pend) rsp_valid[rsp_idx] = 1'b1;
  end

  assign rsp_rdata = (rst_n && !rsp_oor) ? ram_rd_data : '0;
  assign rsp_err   = rsp_oor;

endmodule
